wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone pipelined arbiter.
- Shares the single wb_mem behind the cache between the instruction-fetch cache (m0) and the data cache (m1).
- Grants whole bus cycles (CYC-granular), round-robin, with bounded outstanding requests and a watchdog that errors out hung slave responses.
- Sits between the cache controllers and wb_mem inside the memory top level.

---
 rtl/wb_arb_pkg.sv | 38 +++
 rtl/wb_outstanding_tracker.sv | 64 ++++++
 rtl/wb_arbiter_2m.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types for the two-master Wishbone arbiter
package wb_arb_pkg;

    localparam int WB_AW = 12;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
    } wb_req_t;

    typedef struct packed {
        logic             stall;
        logic             ack;
        logic             err;
        logic [WB_DW-1:0] dat;
    } wb_rsp_t;

    // What an ungranted master sees: held off, no responses, quiet data
    localparam wb_rsp_t RSP_IDLE = '{stall: 1'b1, ack: 1'b0, err: 1'b0, dat: '0};

    function automatic logic is_grant(input arb_state_t s);
        return (s == GNT0) || (s == GNT1);
    endfunction

endpackage

// File: rtl/wb_outstanding_tracker.sv
// rtl/wb_outstanding_tracker.sv - outstanding-request counter, cap flag and response watchdog
module wb_outstanding_tracker #(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255,
    localparam int CW = $clog2(MAX_OUT + 1),
    localparam int WW = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic accept,
    input  logic resp,
    input  logic clear,
    output logic cap,
    output logic timeout
);

    logic [CW-1:0] out_q, out_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          busy;
    logic          resp_v;

    // Flags are decoded from registered state only, so they never depend on this cycle's bus inputs
    always_comb begin
        busy    = (out_q != '0);
        resp_v  = resp & busy;
        cap     = (out_q == CW'(MAX_OUT));
        timeout = active & busy & (wdog_q == WW'(TIMEOUT));
    end

    // Counter: +1 per accepted strobe, -1 per response; a stray response at zero is dropped
    always_comb begin
        out_d = out_q;
        if (clear) begin
            out_d = '0;
        end else if (accept && !resp_v) begin
            out_d = out_q + CW'(1);
        end else if (!accept && resp_v) begin
            out_d = out_q - CW'(1);
        end
    end

    // Watchdog counts silent granted cycles while something is still owed by the slave
    always_comb begin
        wdog_d = wdog_q;
        if (clear || resp || !busy || !active) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            wdog_q <= '0;
        end else begin
            out_q  <= out_d;
            wdog_q <= wdog_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone pipelined arbiter with watchdog
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          cpu_clock_i,
    input  logic          cpu_reset_ni,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    output logic          m0_stall_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [31:0]   m0_dat_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    output logic          m1_stall_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [31:0]   m1_dat_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    input  logic          s_stall_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic [31:0]   s_dat_i
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;

    wb_req_t    req0, req1, req_g;
    wb_rsp_t    rsp_g, rsp0, rsp1;

    logic       granted;
    logic       gsel;
    logic       cap;
    logic       timeout;
    logic       accept;
    logic       release_c;
    logic       clear;

    // Gather each master's request into one record so the grant mux is a single select
    always_comb begin
        req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                 adr: WB_AW'(m0_adr_i), dat: m0_dat_i, sel: m0_sel_i};
        req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                 adr: WB_AW'(m1_adr_i), dat: m1_dat_i, sel: m1_sel_i};
    end

    // Slave-side mux: the granted master drives the bus, everything else is forced quiet
    always_comb begin
        granted   = is_grant(state_q);
        gsel      = (state_q == GNT1);
        req_g     = gsel ? req1 : req0;

        s_cyc_o   = granted & req_g.cyc;
        s_stb_o   = s_cyc_o & req_g.stb & ~cap & ~timeout;
        s_we_o    = granted & req_g.we;
        s_adr_o   = granted ? AW'(req_g.adr) : '0;
        s_dat_o   = granted ? req_g.dat : '0;
        s_sel_o   = granted ? req_g.sel : '0;

        accept    = s_stb_o & ~s_stall_i;
        release_c = granted & ~req_g.cyc;
        clear     = ~granted | release_c | timeout;
    end

    // Master-side mux: only the grant holder sees slave responses; the timeout shows up as one err pulse
    always_comb begin
        rsp_g = '{stall: s_stall_i | cap | timeout,
                  ack:   s_ack_i,
                  err:   s_err_i | timeout,
                  dat:   s_dat_i};
        rsp0  = (state_q == GNT0) ? rsp_g : RSP_IDLE;
        rsp1  = (state_q == GNT1) ? rsp_g : RSP_IDLE;

        m0_stall_o = rsp0.stall;
        m0_ack_o   = rsp0.ack;
        m0_err_o   = rsp0.err;
        m0_dat_o   = rsp0.dat;
        m1_stall_o = rsp1.stall;
        m1_ack_o   = rsp1.ack;
        m1_err_o   = rsp1.err;
        m1_dat_o   = rsp1.dat;
    end

    wb_outstanding_tracker #(
        .MAX_OUT (MAX_OUT),
        .TIMEOUT (TIMEOUT)
    ) u_tracker (
        .clk     (cpu_clock_i),
        .rst_n   (cpu_reset_ni),
        .active  (granted),
        .accept  (accept),
        .resp    (s_ack_i | s_err_i),
        .clear   (clear),
        .cap     (cap),
        .timeout (timeout)
    );

    // Grant sequencing: whole-cycle grants, round-robin on ties, watchdog forces an abort
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (timeout) begin
                    state_d      = ABORT;
                    last_grant_d = gsel;
                end else if (release_c) begin
                    state_d      = IDLE;
                    last_grant_d = gsel;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant registers; last_grant resets to m1 so m0 wins the first tie
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - randomized and directed bench with a behavioural arbiter model
module tb_wb_arbiter_2m;

    localparam int AW      = 12;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [31:0]   m0_dat_i;
    logic [3:0]    m0_sel_i;
    logic          m0_stall_o, m0_ack_o, m0_err_o;
    logic [31:0]   m0_dat_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [31:0]   m1_dat_i;
    logic [3:0]    m1_sel_i;
    logic          m1_stall_o, m1_ack_o, m1_err_o;
    logic [31:0]   m1_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_stall_i, s_ack_i, s_err_i;
    logic [31:0]   s_dat_i;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.AW(AW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
        .cpu_clock_i (clk),        .cpu_reset_ni (rst_n),
        .m0_cyc_i    (m0_cyc_i),   .m0_stb_i     (m0_stb_i),   .m0_we_i  (m0_we_i),
        .m0_adr_i    (m0_adr_i),   .m0_dat_i     (m0_dat_i),   .m0_sel_i (m0_sel_i),
        .m0_stall_o  (m0_stall_o), .m0_ack_o     (m0_ack_o),   .m0_err_o (m0_err_o),
        .m0_dat_o    (m0_dat_o),
        .m1_cyc_i    (m1_cyc_i),   .m1_stb_i     (m1_stb_i),   .m1_we_i  (m1_we_i),
        .m1_adr_i    (m1_adr_i),   .m1_dat_i     (m1_dat_i),   .m1_sel_i (m1_sel_i),
        .m1_stall_o  (m1_stall_o), .m1_ack_o     (m1_ack_o),   .m1_err_o (m1_err_o),
        .m1_dat_o    (m1_dat_o),
        .s_cyc_o     (s_cyc_o),    .s_stb_o      (s_stb_o),    .s_we_o   (s_we_o),
        .s_adr_o     (s_adr_o),    .s_dat_o      (s_dat_o),    .s_sel_o  (s_sel_o),
        .s_stall_i   (s_stall_i),  .s_ack_i      (s_ack_i),    .s_err_i  (s_err_i),
        .s_dat_i     (s_dat_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: who holds the bus (-1 nobody), abort drain flag, owed responses, silent cycles, last holder
    int holder, pending, quiet, last_owner;
    bit aborting;

    // Observations collected while stepping
    int          cyc_n, acc_n, acc_at, err0_n, err_at;
    logic [31:0] ack0_q[$], ack1_q[$];
    logic        o_m0_stall, o_m1_stall, o_s_cyc;

    task automatic model_reset();
        holder = -1; aborting = 0; pending = 0; quiet = 0; last_owner = 1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_stall_i = 0; s_ack_i = 0; s_err_i = 0; s_dat_i = '0;
    endtask

    task automatic clr_obs();
        acc_n = 0; acc_at = -1; err0_n = 0; err_at = -1;
        ack0_q.delete(); ack1_q.delete();
    endtask

    // One clock: inputs were set at edge+1; compare at edge+3, then advance the model past the edge
    task automatic tick();
        logic [1:0]    mc, ms, mw;
        logic [AW-1:0] ma [2];
        logic [31:0]   md [2];
        logic [3:0]    mq [2];
        logic [2:0]    e_sctl, e_r0, e_r1, rsp;
        logic [AW-1:0] e_adr;
        logic [31:0]   e_sdat, e_d0, e_d1;
        logic [3:0]    e_sel;
        bit            full, fired, took, stb;
        int            h;
        #2;
        mc = {m1_cyc_i, m0_cyc_i}; ms = {m1_stb_i, m0_stb_i}; mw = {m1_we_i, m0_we_i};
        ma[0] = m0_adr_i; ma[1] = m1_adr_i; md[0] = m0_dat_i; md[1] = m1_dat_i;
        mq[0] = m0_sel_i; mq[1] = m1_sel_i;
        e_sctl = 3'b000; e_adr = '0; e_sdat = '0; e_sel = '0;
        e_r0 = 3'b100; e_r1 = 3'b100; e_d0 = '0; e_d1 = '0;
        fired = 0; took = 0; h = holder;
        if (holder >= 0 && !aborting) begin
            full   = (pending == MAX_OUT);
            fired  = (pending > 0) && (quiet == TIMEOUT);
            stb    = mc[h] && ms[h] && !full && !fired;
            e_sctl = {mc[h], stb, mw[h]};
            e_adr  = ma[h]; e_sdat = md[h]; e_sel = mq[h];
            rsp    = {s_stall_i | full | fired, s_ack_i, s_err_i | fired};
            if (h == 0) begin e_r0 = rsp; e_d0 = s_dat_i; end
            else        begin e_r1 = rsp; e_d1 = s_dat_i; end
            took   = stb && !s_stall_i;
        end
        check("s_ctl",  32'({s_cyc_o, s_stb_o, s_we_o}), 32'(e_sctl));
        check("s_adr",  32'(s_adr_o), 32'(e_adr));
        check("s_dat",  s_dat_o, e_sdat);
        check("s_sel",  32'(s_sel_o), 32'(e_sel));
        check("m0_rsp", 32'({m0_stall_o, m0_ack_o, m0_err_o}), 32'(e_r0));
        check("m0_dat", m0_dat_o, e_d0);
        check("m1_rsp", 32'({m1_stall_o, m1_ack_o, m1_err_o}), 32'(e_r1));
        check("m1_dat", m1_dat_o, e_d1);
        o_m0_stall = m0_stall_o; o_m1_stall = m1_stall_o; o_s_cyc = s_cyc_o;
        if (s_stb_o && !s_stall_i) begin acc_n++; acc_at = cyc_n; end
        if (m0_err_o) begin err0_n++; err_at = cyc_n; end
        if (m0_ack_o) ack0_q.push_back(m0_dat_o);
        if (m1_ack_o) ack1_q.push_back(m1_dat_o);
        @(posedge clk);
        #1;
        cyc_n++;
        if (holder < 0) begin
            if (mc[0] && mc[1]) holder = 1 - last_owner;
            else if (mc[0])     holder = 0;
            else if (mc[1])     holder = 1;
        end else if (aborting) begin
            holder = -1; aborting = 0;
        end else if (fired) begin
            aborting = 1; last_owner = h; pending = 0; quiet = 0;
        end else if (!mc[h]) begin
            last_owner = h; holder = -1; pending = 0; quiet = 0;
        end else begin
            quiet   = (s_ack_i || s_err_i || pending == 0) ? 0 : quiet + 1;
            pending = pending + (took ? 1 : 0) - (((s_ack_i || s_err_i) && pending > 0) ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        logic [31:0] v;
        cyc_n = 0;
        clr_obs();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        check("rst_s_ctl", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
        check("rst_stall", 32'({m0_stall_o, m1_stall_o}), 32'd3);
        check("rst_resp",  32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
        check("rst_bus",   32'(s_adr_o) | s_dat_o | 32'(s_sel_o) | m0_dat_o | m1_dat_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // m1 two-beat pipelined read
        clr_obs();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 12'h010;
        tick();
        tick();
        m1_adr_i = 12'h011;
        tick();
        m1_stb_i = 0; s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
        tick();
        s_dat_i = 32'h12345678;
        tick();
        s_ack_i = 0; m1_cyc_i = 0;
        tick();
        tick();
        check("t1_acks", ack1_q.size(), 2);
        v = (ack1_q.size() > 0) ? ack1_q[0] : 32'h0;
        check("t1_dat0", v, 32'hDEADBEEF);
        v = (ack1_q.size() > 1) ? ack1_q[1] : 32'h0;
        check("t1_dat1", v, 32'h12345678);
        check("t1_m0_acks", ack0_q.size(), 0);

        // Round-robin alternation from reset
        do_reset();
        m0_cyc_i = 1; m1_cyc_i = 1;
        for (int i = 0; i < 4; i++) begin
            g = -1;
            for (int w = 0; w < 4 && g < 0; w++) begin
                tick();
                if (!o_m0_stall)      g = 0;
                else if (!o_m1_stall) g = 1;
            end
            check("t2_order", g, i % 2);
            if (g == 0) m0_cyc_i = 0;
            if (g == 1) m1_cyc_i = 0;
            tick();
            m0_cyc_i = 1; m1_cyc_i = 1;
        end
        m0_cyc_i = 0; m1_cyc_i = 0;
        repeat (3) tick();

        // Outstanding cap with a silent, non-stalling slave
        clr_obs();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            m0_adr_i = AW'($urandom); m0_dat_i = $urandom;
            tick();
        end
        check("t3_accepted", acc_n, MAX_OUT);
        check("t3_stall", 32'(o_m0_stall), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        repeat (2) tick();

        // Watchdog timeout on a single owed response
        clr_obs();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tick();
        m0_stb_i = 0;
        for (int w = 0; w < 300 && err0_n == 0; w++) tick();
        tick();
        check("t4_abort_cyc", 32'(o_s_cyc), 32'd0);
        check("t4_abort_stall", 32'({o_m0_stall, o_m1_stall}), 32'd3);
        check("t4_err_count", err0_n, 1);
        check("t4_err_delay", err_at - acc_at, TIMEOUT + 1);
        m0_cyc_i = 0;
        repeat (3) tick();

        // Asynchronous reset mid-burst, then a fresh transfer
        clr_obs();
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (3) tick();
        #2;
        rst_n = 0;
        #1;
        check("t5_s_cyc", 32'(s_cyc_o), 32'd0);
        check("t5_s_stb", 32'(s_stb_o), 32'd0);
        check("t5_stalls", 32'({m0_stall_o, m1_stall_o}), 32'd3);
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        clr_obs();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tick();
        m0_stb_i = 0; s_ack_i = 1; s_dat_i = 32'hCAFEF00D;
        tick();
        s_ack_i = 0; m0_cyc_i = 0;
        repeat (2) tick();
        check("t5_acks", ack0_q.size(), 1);
        v = (ack0_q.size() > 0) ? ack0_q[0] : 32'h0;
        check("t5_dat", v, 32'hCAFEF00D);

        // m1 abandons two requests; late acks must vanish; m0 then starts from zero outstanding
        clr_obs();
        m1_cyc_i = 1; m1_stb_i = 1;
        repeat (3) tick();
        m1_stb_i = 0; m1_cyc_i = 0;
        tick();
        s_ack_i = 1;
        repeat (2) tick();
        s_ack_i = 0;
        check("t6_late_acks", ack0_q.size() + ack1_q.size(), 0);
        clr_obs();
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (6) tick();
        check("t6_accepted", acc_n, MAX_OUT);
        m0_cyc_i = 0; m0_stb_i = 0;
        repeat (2) tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(7) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = 1'($urandom); m0_we_i = 1'($urandom);
            m0_adr_i = AW'($urandom); m0_dat_i = $urandom; m0_sel_i = 4'($urandom);
            m1_stb_i = 1'($urandom); m1_we_i = 1'($urandom);
            m1_adr_i = AW'($urandom); m1_dat_i = $urandom; m1_sel_i = 4'($urandom);
            s_stall_i = ($urandom_range(3) == 0);
            s_ack_i   = ($urandom_range(2) == 0);
            s_err_i   = ($urandom_range(19) == 0);
            s_dat_i   = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
